// File: rtl/mem_str_fwd_unit.sv
// Store-data forwarding unit: predicts one-hot mux selects for the store entering EX/MEM
// and keeps the MEM/WB history (tm1) data that serves as the oldest forwarding source.
module mem_str_fwd_unit (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       stall,
  input  logic       flush,
  input  logic       id_ex_str_valid,
  input  logic [3:0] id_ex_rs_top,
  input  logic [3:0] id_ex_rs_bot,
  input  logic       ex_mem_wr_en_top,
  input  logic       ex_mem_wr_en_bot,
  input  logic [3:0] ex_mem_rd_top,
  input  logic [3:0] ex_mem_rd_bot,
  input  logic       mem_wb_wr_en_top,
  input  logic       mem_wb_wr_en_bot,
  input  logic [3:0] mem_wb_rd_top,
  input  logic [3:0] mem_wb_rd_bot,
  input  logic [7:0] mem_wb_data_top,
  input  logic [7:0] mem_wb_data_bot,
  output logic [4:0] sel_signal_top,
  output logic [4:0] sel_signal_bot,
  output logic [7:0] mem_wb_tm1_data_top,
  output logic [7:0] mem_wb_tm1_data_bot
);

  localparam logic [4:0] SelOwn   = 5'b00001;
  localparam logic [4:0] SelWbTop = 5'b00010;
  localparam logic [4:0] SelWbBot = 5'b00100;
  localparam logic [4:0] SelT1Top = 5'b01000;
  localparam logic [4:0] SelT1Bot = 5'b10000;

  logic [4:0] sel_top_d, sel_top_q;
  logic [4:0] sel_bot_d, sel_bot_q;
  logic [7:0] tm1_top_d, tm1_top_q;
  logic [7:0] tm1_bot_d, tm1_bot_q;
  logic       advance;

  // EX/MEM producers become MEM/WB next cycle; MEM/WB producers become tm1.
  function automatic logic [4:0] pick_sel(input logic [3:0] rs);
    logic [4:0] sel;
    sel = SelOwn;
    if (!id_ex_str_valid) begin
      sel = SelOwn;
    end else if (ex_mem_wr_en_top && (ex_mem_rd_top == rs)) begin
      sel = SelWbTop;
    end else if (ex_mem_wr_en_bot && (ex_mem_rd_bot == rs)) begin
      sel = SelWbBot;
    end else if (mem_wb_wr_en_top && (mem_wb_rd_top == rs)) begin
      sel = SelT1Top;
    end else if (mem_wb_wr_en_bot && (mem_wb_rd_bot == rs)) begin
      sel = SelT1Bot;
    end
    return sel;
  endfunction

  // Flush still advances history: only the incoming store is squashed.
  assign advance = !stall || flush;

  always_comb begin
    sel_top_d = sel_top_q;
    sel_bot_d = sel_bot_q;
    tm1_top_d = tm1_top_q;
    tm1_bot_d = tm1_bot_q;
    if (flush) begin
      sel_top_d = SelOwn;
      sel_bot_d = SelOwn;
    end else if (!stall) begin
      sel_top_d = pick_sel(id_ex_rs_top);
      sel_bot_d = pick_sel(id_ex_rs_bot);
    end
    if (advance) begin
      tm1_top_d = mem_wb_data_top;
      tm1_bot_d = mem_wb_data_bot;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_top_q <= SelOwn;
      sel_bot_q <= SelOwn;
      tm1_top_q <= 8'h00;
      tm1_bot_q <= 8'h00;
    end else begin
      sel_top_q <= sel_top_d;
      sel_bot_q <= sel_bot_d;
      tm1_top_q <= tm1_top_d;
      tm1_bot_q <= tm1_bot_d;
    end
  end

  assign sel_signal_top      = sel_top_q;
  assign sel_signal_bot      = sel_bot_q;
  assign mem_wb_tm1_data_top = tm1_top_q;
  assign mem_wb_tm1_data_bot = tm1_bot_q;

endmodule

// File: tb/tb_mem_str_fwd_unit.sv
// Scoreboard bench for mem_str_fwd_unit: directed vectors push hand-computed expectations,
// an independent monitor pops and compares after each clock edge or reset assertion.
module tb_mem_str_fwd_unit;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       stall, flush, id_ex_str_valid;
  logic [3:0] id_ex_rs_top, id_ex_rs_bot;
  logic       ex_mem_wr_en_top, ex_mem_wr_en_bot;
  logic [3:0] ex_mem_rd_top, ex_mem_rd_bot;
  logic       mem_wb_wr_en_top, mem_wb_wr_en_bot;
  logic [3:0] mem_wb_rd_top, mem_wb_rd_bot;
  logic [7:0] mem_wb_data_top, mem_wb_data_bot;
  logic [4:0] sel_signal_top, sel_signal_bot;
  logic [7:0] mem_wb_tm1_data_top, mem_wb_tm1_data_bot;

  typedef struct {
    string      name;
    logic [4:0] st;
    logic [4:0] sb;
    logic [7:0] tt;
    logic [7:0] tb;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rst_seen = 1'b0;

  mem_str_fwd_unit dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .stall               (stall),
    .flush               (flush),
    .id_ex_str_valid     (id_ex_str_valid),
    .id_ex_rs_top        (id_ex_rs_top),
    .id_ex_rs_bot        (id_ex_rs_bot),
    .ex_mem_wr_en_top    (ex_mem_wr_en_top),
    .ex_mem_wr_en_bot    (ex_mem_wr_en_bot),
    .ex_mem_rd_top       (ex_mem_rd_top),
    .ex_mem_rd_bot       (ex_mem_rd_bot),
    .mem_wb_wr_en_top    (mem_wb_wr_en_top),
    .mem_wb_wr_en_bot    (mem_wb_wr_en_bot),
    .mem_wb_rd_top       (mem_wb_rd_top),
    .mem_wb_rd_bot       (mem_wb_rd_bot),
    .mem_wb_data_top     (mem_wb_data_top),
    .mem_wb_data_bot     (mem_wb_data_bot),
    .sel_signal_top      (sel_signal_top),
    .sel_signal_bot      (sel_signal_bot),
    .mem_wb_tm1_data_top (mem_wb_tm1_data_top),
    .mem_wb_tm1_data_bot (mem_wb_tm1_data_bot)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: one-hot on every edge, scoreboard compare whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock or negedge reset_n);
      #1;
      if (rst_seen) begin
        chk("onehot_top", 8'($countones(sel_signal_top)), 8'd1);
        chk("onehot_bot", 8'($countones(sel_signal_bot)), 8'd1);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".sel_top"}, {3'b000, sel_signal_top}, {3'b000, e.st});
        chk({e.name, ".sel_bot"}, {3'b000, sel_signal_bot}, {3'b000, e.sb});
        chk({e.name, ".tm1_top"}, mem_wb_tm1_data_top, e.tt);
        chk({e.name, ".tm1_bot"}, mem_wb_tm1_data_bot, e.tb);
      end
    end
  end

  task automatic push(input string nm, input logic [4:0] st, input logic [4:0] sb,
                      input logic [7:0] tt, input logic [7:0] tb);
    exp_t e;
    e.name = nm; e.st = st; e.sb = sb; e.tt = tt; e.tb = tb;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    stall = 0; flush = 0; id_ex_str_valid = 0;
    id_ex_rs_top = 0; id_ex_rs_bot = 0;
    ex_mem_wr_en_top = 0; ex_mem_wr_en_bot = 0; ex_mem_rd_top = 0; ex_mem_rd_bot = 0;
    mem_wb_wr_en_top = 0; mem_wb_wr_en_bot = 0; mem_wb_rd_top = 0; mem_wb_rd_bot = 0;
    mem_wb_data_top = 0; mem_wb_data_bot = 0;
  endtask

  // Asserts reset at a negedge: checked immediately, at the edge inside reset,
  // and at the first edge after release (inputs idle, store invalid).
  task automatic reset_pulse(input string nm);
    @(negedge clock);
    rst_seen = 1'b1;
    push({nm, "_async"}, 5'b00001, 5'b00001, 8'h00, 8'h00);
    push({nm, "_held"}, 5'b00001, 5'b00001, 8'h00, 8'h00);
    reset_n = 1'b0;
    @(negedge clock);
    idle();
    push({nm, "_release"}, 5'b00001, 5'b00001, 8'h00, 8'h00);
    reset_n = 1'b1;
  endtask

  task automatic step(input string nm, input logic v, input logic st, input logic fl,
                      input logic [3:0] rt, input logic [3:0] rb,
                      input logic eet, input logic eeb, input logic [3:0] ert,
                      input logic [3:0] erb, input logic wet, input logic web,
                      input logic [3:0] wrt, input logic [3:0] wrb,
                      input logic [7:0] wdt, input logic [7:0] wdb,
                      input logic [4:0] xst, input logic [4:0] xsb,
                      input logic [7:0] xtt, input logic [7:0] xtb);
    @(negedge clock);
    id_ex_str_valid = v; stall = st; flush = fl;
    id_ex_rs_top = rt; id_ex_rs_bot = rb;
    ex_mem_wr_en_top = eet; ex_mem_wr_en_bot = eeb; ex_mem_rd_top = ert; ex_mem_rd_bot = erb;
    mem_wb_wr_en_top = wet; mem_wb_wr_en_bot = web; mem_wb_rd_top = wrt; mem_wb_rd_bot = wrb;
    mem_wb_data_top = wdt; mem_wb_data_bot = wdb;
    push(nm, xst, xsb, xtt, xtb);
  endtask

  initial begin
    idle();
    reset_pulse("por");
    //   name           v st fl rt rb   eet eeb ert erb  wet web wrt wrb  wdt    wdb
    step("ex_bot_newest", 1, 0, 0, 4'h1, 4'h3, 0, 1, 4'h0, 4'h3, 1, 0, 4'h3, 4'h0, 8'h11, 8'h22,
         5'b00001, 5'b00100, 8'h11, 8'h22);
    step("tm1_path",      1, 0, 0, 4'h7, 4'h4, 0, 0, 4'h5, 4'h6, 0, 1, 4'h7, 4'h7, 8'h3C, 8'hA5,
         5'b10000, 5'b00001, 8'h3C, 8'hA5);
    step("dual_ex",       1, 0, 0, 4'h2, 4'h2, 1, 1, 4'h2, 4'h2, 1, 1, 4'h2, 4'h2, 8'h01, 8'h02,
         5'b00010, 5'b00010, 8'h01, 8'h02);
    step("wb_top_wins",   1, 0, 0, 4'h9, 4'h8, 1, 1, 4'h1, 4'h8, 1, 1, 4'h9, 4'h9, 8'h44, 8'h55,
         5'b01000, 5'b00100, 8'h44, 8'h55);
    step("reg_zero",      1, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 1, 4'h0, 4'h0, 8'h66, 8'h77,
         5'b10000, 5'b10000, 8'h66, 8'h77);
    step("no_store",      0, 0, 0, 4'h5, 4'h5, 1, 1, 4'h5, 4'h5, 1, 1, 4'h5, 4'h5, 8'h88, 8'h99,
         5'b00001, 5'b00001, 8'h88, 8'h99);
    step("wr_disabled",   1, 0, 0, 4'h6, 4'h6, 0, 0, 4'h6, 4'h6, 0, 0, 4'h6, 4'h6, 8'hAA, 8'hBB,
         5'b00001, 5'b00001, 8'hAA, 8'hBB);
    step("pre_stall",     1, 0, 0, 4'h4, 4'h4, 0, 0, 4'h0, 4'h0, 1, 0, 4'h4, 4'h0, 8'h12, 8'h34,
         5'b01000, 5'b01000, 8'h12, 8'h34);
    step("stall_1",       1, 1, 0, 4'h4, 4'h4, 1, 0, 4'h4, 4'h0, 0, 0, 4'h0, 4'h0, 8'hDE, 8'hAD,
         5'b01000, 5'b01000, 8'h12, 8'h34);
    step("stall_2",       1, 1, 0, 4'h3, 4'h4, 0, 1, 4'h0, 4'h4, 0, 1, 4'h0, 4'h3, 8'hBE, 8'hEF,
         5'b01000, 5'b01000, 8'h12, 8'h34);
    step("stall_3",       0, 1, 0, 4'h1, 4'h2, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 8'hF0, 8'h0F,
         5'b01000, 5'b01000, 8'h12, 8'h34);
    step("flush_stall",   1, 1, 1, 4'h4, 4'h4, 1, 1, 4'h4, 4'h4, 0, 0, 4'h0, 4'h0, 8'hC3, 8'hD4,
         5'b00001, 5'b00001, 8'hC3, 8'hD4);
    step("flush_only",    1, 0, 1, 4'h4, 4'h4, 1, 1, 4'h4, 4'h4, 1, 1, 4'h4, 4'h4, 8'hE5, 8'hF6,
         5'b00001, 5'b00001, 8'hE5, 8'hF6);
    step("pre_reset",     1, 0, 0, 4'h4, 4'h4, 0, 0, 4'h0, 4'h0, 1, 0, 4'h4, 4'h0, 8'h21, 8'h43,
         5'b01000, 5'b01000, 8'h21, 8'h43);
    reset_pulse("midrun_rst");
    step("after_reset",   1, 0, 0, 4'hA, 4'hB, 1, 1, 4'hB, 4'hA, 0, 0, 4'h0, 4'h0, 8'h5A, 8'hA5,
         5'b00100, 5'b00010, 8'h5A, 8'hA5);

    // Random traffic: only the one-hot property is checked by the monitor here.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      stall            = ($urandom_range(0, 3) == 0);
      flush            = ($urandom_range(0, 7) == 0);
      id_ex_str_valid  = 1'($urandom_range(0, 1));
      id_ex_rs_top     = 4'($urandom_range(0, 15));
      id_ex_rs_bot     = 4'($urandom_range(0, 15));
      ex_mem_wr_en_top = 1'($urandom_range(0, 1));
      ex_mem_wr_en_bot = 1'($urandom_range(0, 1));
      ex_mem_rd_top    = 4'($urandom_range(0, 15));
      ex_mem_rd_bot    = 4'($urandom_range(0, 15));
      mem_wb_wr_en_top = 1'($urandom_range(0, 1));
      mem_wb_wr_en_bot = 1'($urandom_range(0, 1));
      mem_wb_rd_top    = 4'($urandom_range(0, 15));
      mem_wb_rd_bot    = 4'($urandom_range(0, 15));
      mem_wb_data_top  = 8'($urandom_range(0, 255));
      mem_wb_data_bot  = 8'($urandom_range(0, 255));
    end

    @(negedge clock);
    idle();
    @(posedge clock);
    #2;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_str_fwd_unit.md
# mem_str_fwd_unit

Store-data forwarding unit for the memory stage. It produces the one-hot `sel_signal_top`/`sel_signal_bot` buses that drive `mem_str_data_sel_mux`. It also holds the `mem_wb_tm1` history data registers that the mux uses as its oldest forwarding source. Selects are computed one cycle early, from the store in ID/EX and the producers in EX/MEM and MEM/WB, and are registered so they are valid when the store reaches EX/MEM.

## Interface
- No parameters. Register addresses are 4 bits wide; data halves are 8 bits wide.
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  global pipeline freeze; all state holds
- `flush`  in  1  squash the store entering EX/MEM
- `id_ex_str_valid`  in  1  ID/EX holds a valid store
- `id_ex_rs_top`, `id_ex_rs_bot`  in  4 each  store source registers (top nibble, bottom byte)
- `ex_mem_wr_en_top`, `ex_mem_wr_en_bot`  in  1 each  EX/MEM instruction writes its top/bot destination
- `ex_mem_rd_top`, `ex_mem_rd_bot`  in  4 each  EX/MEM destination registers
- `mem_wb_wr_en_top`, `mem_wb_wr_en_bot`  in  1 each  MEM/WB write enables
- `mem_wb_rd_top`, `mem_wb_rd_bot`  in  4 each  MEM/WB destination registers
- `mem_wb_data_top`, `mem_wb_data_bot`  in  8 each  MEM/WB writeback data
- `sel_signal_top`, `sel_signal_bot`  out  5 each  registered one-hot mux selects
- `mem_wb_tm1_data_top`, `mem_wb_tm1_data_bot`  out  8 each  MEM/WB data delayed by one advancing cycle

## Operation
- Select encoding, shared with the mux:
  - [0] own EX/MEM data (no hazard)
  - [1] MEM/WB top
  - [2] MEM/WB bot
  - [3] tm1 top
  - [4] tm1 bot
- Each select is always exactly one-hot.
- Next-cycle prediction on an advancing edge:
  - The current EX/MEM destinations become the MEM/WB sources, via [1]/[2].
  - The current MEM/WB destinations become the tm1 sources, via [3]/[4].
- Next-select rule, evaluated independently for `rs` = `id_ex_rs_bot` (giving `sel_signal_bot`) and `rs` = `id_ex_rs_top` (giving `sel_signal_top`):
  - If `id_ex_str_valid` = 0, the next select is 5'b00001.
  - Otherwise the first match wins, in this order:
    - `ex_mem_wr_en_top` && `ex_mem_rd_top` == `rs` → 5'b00010
    - `ex_mem_wr_en_bot` && `ex_mem_rd_bot` == `rs` → 5'b00100
    - `mem_wb_wr_en_top` && `mem_wb_rd_top` == `rs` → 5'b01000
    - `mem_wb_wr_en_bot` && `mem_wb_rd_bot` == `rs` → 5'b10000
    - no match → 5'b00001
- Newest producer wins; within one instruction, top wins over bot.
- tm1 data: on an advancing edge, `mem_wb_tm1_data_top/bot` load `mem_wb_data_top/bot` unconditionally. Write enables do not gate the load, because the selects already encode validity.
- Register address 0 is not special; it forwards like any other register.
- The top nibble uses only `[3:0]` of the selected source; that truncation is done in the mux, not here.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `sel_signal_top` = `sel_signal_bot` = 5'b00001
  - both tm1 data outputs = 8'h00
  - These values hold while reset is asserted and for the first edge after release if `id_ex_str_valid` = 0.
- Latency: prediction is registered, one cycle. Inputs sampled at edge N give the selects used during cycle N+1, when the store sits in EX/MEM.
- `stall` = 1 and `flush` = 0: all registers hold their values.
- `flush` = 1, with or without `stall` (flush takes priority): selects load 5'b00001. tm1 data still advances, because older instructions are not squashed.
- Reset deasserted mid-operation: the pipeline restarts from the reset values. No partial state survives.
- All outputs are driven directly from flops; there is no combinational input-to-output path.

## Test plan
- Reset: assert `reset_n` = 0 mid-run with selects at 5'b01000 → both selects read 5'b00001 and tm1 data reads 8'h00 immediately, before any clock edge.
- EX/MEM hazard: `id_ex_rs_bot` = 4'h3, `ex_mem_rd_bot` = 4'h3, `ex_mem_wr_en_bot` = 1, `mem_wb_rd_top` = 4'h3 with enable = 1 → after the edge, `sel_signal_bot` = 5'b00100 (newest wins).
- tm1 path: `id_ex_rs_top` = 4'h7, only `mem_wb_rd_bot` = 4'h7 enabled, `mem_wb_data_bot` = 8'hA5 → after the edge:
  - `sel_signal_top` = 5'b10000
  - `mem_wb_tm1_data_bot` = 8'hA5
- Dual match in one producer: `ex_mem_rd_top` = `ex_mem_rd_bot` = 4'h2, both enabled, rs = 4'h2 → 5'b00010.
- Stall/flush:
  - Set a hazard giving 5'b01000, then `stall` = 1 for 3 cycles with changing inputs → select and tm1 data are frozen.
  - Then `flush` = 1 together with `stall` = 1 → select = 5'b00001.
- Non-store or disabled producer: `id_ex_str_valid` = 0 with matching addresses → 5'b00001. Matching address with write enable = 0 → 5'b00001.
- One-hot check: random stimulus for 10k cycles → each select always has exactly one bit set.
